gmem_fill_engine: RTL

//  - Writer-side master for the graphics memory (gmem port A, sys_clk_i domain); the video path reads port B.
//  - Accepts rectangle-fill commands (x0, y0, w, h, colour) from the CPU-side peripheral.
//  - Emits one RGB565 pixel write per cycle into the row-major frame buffer: addr = y*FB_W + x.

---
 rtl/gmem_pkg.sv | 29 ++
 rtl/gmem_rect_clip.sv | 40 ++++
 rtl/gmem_fill_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gmem_pkg.sv
// ----------------------------------------------------------------------------
// gmem_pkg
// Purpose : Shared frame-buffer geometry and gmem port widths for the
//           graphics memory writers and the video read path, plus the
//           state encoding of the rectangle-fill engine.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package gmem_pkg;

  // Frame-buffer geometry; FB_W is also the row pitch in gmem words.
  localparam int FB_W   = 160;
  localparam int FB_H   = 120;

  // gmem port widths; DATA_W carries one RGB565 pixel.
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  // Width of the x0/y0/w/h fields of a fill command.
  localparam int XY_W   = 8;

  // Fill engine sequencing: IDLE -> SETUP -> FILL -> DONE -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/gmem_rect_clip.sv
// ----------------------------------------------------------------------------
// gmem_rect_clip
// Purpose : Combinational clip of a fill rectangle to the frame buffer.
//           The effective width/height are limited to the room left between
//           the origin and the right/bottom edge; an origin outside the
//           frame buffer yields a zero-sized rectangle.
// Ports   : i_x0, i_y0  rectangle origin (column, row)
//           i_w,  i_h   requested width/height in pixels
//           o_w,  o_h   effective width/height after clipping
// ----------------------------------------------------------------------------
module gmem_rect_clip
  import gmem_pkg::*;
(
  input  logic [XY_W-1:0] i_x0,
  input  logic [XY_W-1:0] i_y0,
  input  logic [XY_W-1:0] i_w,
  input  logic [XY_W-1:0] i_h,
  output logic [XY_W-1:0] o_w,
  output logic [XY_W-1:0] o_h
);

  logic [XY_W-1:0] w_roomX;
  logic [XY_W-1:0] w_roomY;

  // Room to the right/bottom edge is zero when the origin already lies
  // outside the frame buffer, which turns the command into a no-op.
  always_comb begin
    w_roomX = '0;
    w_roomY = '0;
    if (i_x0 < XY_W'(FB_W)) begin
      w_roomX = XY_W'(FB_W) - i_x0;
    end
    if (i_y0 < XY_W'(FB_H)) begin
      w_roomY = XY_W'(FB_H) - i_y0;
    end
    o_w = (i_w < w_roomX) ? i_w : w_roomX;
    o_h = (i_h < w_roomY) ? i_h : w_roomY;
  end

endmodule

// File: rtl/gmem_fill_engine.sv
// ----------------------------------------------------------------------------
// gmem_fill_engine
// Purpose : Writer-side master for gmem port A. Accepts rectangle-fill
//           commands and emits one RGB565 pixel write per cycle into the
//           row-major frame buffer (addr = y*FB_W + x, wrapping modulo
//           2**ADDR_W).
// Config  : GMEM_FILL_CLIP_EN - when defined, rectangles are clipped to the
//           frame buffer in SETUP; otherwise they are written as computed.
// Ports   : sys_clk_i          clock (also gmem port-A clock)
//           rst_i              asynchronous reset, active-low
//           cmd_valid_i/_ready_o  command handshake (ready only in IDLE)
//           cmd_x0_i, cmd_y0_i    rectangle origin
//           cmd_w_i,  cmd_h_i     rectangle size (0 = no-op)
//           cmd_color_i           fill colour
//           abort_i            stop the current fill (SETUP/FILL only)
//           busy_o             command in progress (SETUP/FILL/DONE)
//           done_o             one-cycle pulse on normal completion
//           gmemEn_o, gmemWEn_o, gmemAddr_o, gmemWData_o  gmem port A
// ----------------------------------------------------------------------------
module gmem_fill_engine
  import gmem_pkg::*;
(
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [XY_W-1:0]   cmd_x0_i,
  input  logic [XY_W-1:0]   cmd_y0_i,
  input  logic [XY_W-1:0]   cmd_w_i,
  input  logic [XY_W-1:0]   cmd_h_i,
  input  logic [DATA_W-1:0] cmd_color_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              gmemEn_o,
  output logic              gmemWEn_o,
  output logic [ADDR_W-1:0] gmemAddr_o,
  output logic [DATA_W-1:0] gmemWData_o
);

  fill_state_t       r_state;
  logic [XY_W-1:0]   r_x0;
  logic [XY_W-1:0]   r_y0;
  logic [XY_W-1:0]   r_w;
  logic [XY_W-1:0]   r_h;
  logic [DATA_W-1:0] r_color;
  logic [XY_W-1:0]   r_col;
  logic [XY_W-1:0]   r_row;
  logic [ADDR_W-1:0] r_rowBase;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic [XY_W-1:0]   w_effW;
  logic [XY_W-1:0]   w_effH;
  logic [ADDR_W-1:0] w_rowBase;
  logic [ADDR_W-1:0] w_nextBase;
  logic              w_lastCol;
  logic              w_lastRow;

`ifdef GMEM_FILL_CLIP_EN
  // Clip the latched rectangle to the frame buffer before the fill starts.
  gmem_rect_clip u_clip (
    .i_x0 (r_x0),
    .i_y0 (r_y0),
    .i_w  (r_w),
    .i_h  (r_h),
    .o_w  (w_effW),
    .o_h  (w_effH)
  );
`else
  // Without clipping the requested size is used as-is; out-of-range
  // rectangles spill into following rows or wrap around the address space.
  assign w_effW = r_w;
  assign w_effH = r_h;
`endif

  // Address arithmetic is done at ADDR_W bits so it wraps naturally.
  assign w_rowBase  = ADDR_W'(r_y0) * ADDR_W'(FB_W) + ADDR_W'(r_x0);
  assign w_nextBase = r_rowBase + ADDR_W'(FB_W);
  assign w_lastCol  = (r_col == r_w - XY_W'(1));
  assign w_lastRow  = (r_row == r_h - XY_W'(1));

  // The write strobes are registered, but an abort must cancel the write of
  // the very cycle it is seen in, so the enables are gated by abort_i.
  // r_wr is only ever set in FILL, so abort_i has no effect elsewhere.
  assign gmemEn_o    = r_wr & ~abort_i;
  assign gmemWEn_o   = r_wr & ~abort_i;
  assign gmemAddr_o  = r_addr;
  assign gmemWData_o = r_data;
  assign cmd_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

  // Single FSM process: command latch, SETUP address computation, the
  // column/row walk during FILL and all registered outputs. In FILL the
  // outputs show the current pixel while the next pixel is prepared here.
  // Address and data are only updated when a write is launched so they
  // hold their last value between commands.
  always_ff @(posedge sys_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_rowBase <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_wr    <= 1'b0;
          if (cmd_valid_i) begin
            r_x0    <= cmd_x0_i;
            r_y0    <= cmd_y0_i;
            r_w     <= cmd_w_i;
            r_h     <= cmd_h_i;
            r_color <= cmd_color_i;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_col     <= '0;
          r_row     <= '0;
          r_rowBase <= w_rowBase;
          r_w       <= w_effW;
          r_h       <= w_effH;
          if (abort_i) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if ((w_effW == '0) || (w_effH == '0)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wr    <= 1'b1;
            r_addr  <= w_rowBase;
            r_data  <= r_color;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (abort_i) begin
            r_wr    <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_lastCol && w_lastRow) begin
            r_wr    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_lastCol) begin
            r_col     <= '0;
            r_row     <= r_row + XY_W'(1);
            r_rowBase <= w_nextBase;
            r_addr    <= w_nextBase;
          end else begin
            r_col  <= r_col + XY_W'(1);
            r_addr <= r_rowBase + ADDR_W'(r_col) + ADDR_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
